// File: rtl/bcd_down_counter_pkg.sv
// bcd_down_counter_pkg: shared BCD constants and the digit clamp used when loading presets.
package bcd_down_counter_pkg;
   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;
   // Nibbles 10..15 are not valid BCD; they load as 9 so the digit invariant holds.
   function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
      return (d > BCD_NINE) ? BCD_NINE : d;
   endfunction
endpackage

// File: rtl/bcd_down_counter_if.sv
// bcd_down_counter_if: control/data bundle for the BCD down counter.
// in_load/in_d/in_en drive the counter; o_q/o_zero/o_tc/o_done report its state.
interface bcd_down_counter_if #(parameter int DIGITS = 2);
   logic                  in_load;
   logic [4*DIGITS-1:0]   in_d;
   logic                  in_en;
   logic [4*DIGITS-1:0]   o_q;
   logic                  o_zero;
   logic                  o_tc;
   logic                  o_done;
   modport master (output in_load, in_d, in_en, input o_q, o_zero, o_tc, o_done);
   modport slave  (input in_load, in_d, in_en, output o_q, o_zero, o_tc, o_done);
endinterface

// File: rtl/bcd_down_counter_digit_dn.sv
// bcd_digit_dn: single BCD digit down stage.
// Ports: in_clk/in_rst clock and sync reset; in_load/in_d preset; in_borrow decrement request;
// in_hold blocks any change (halt at zero); o_q digit value; o_borrow borrow to next digit.
module bcd_digit_dn
   import bcd_down_counter_pkg::*;
(
   input  logic             in_clk,
   input  logic             in_rst,
   input  logic             in_load,
   input  logic [BCD_W-1:0] in_d,
   input  logic             in_borrow,
   input  logic             in_hold,
   output logic [BCD_W-1:0] o_q,
   output logic             o_borrow
);
   always_ff @(posedge in_clk)
      if (in_rst) o_q <= '0;
      else if (in_load) o_q <= bcd_clamp(in_d);
      else if (in_borrow && !in_hold) o_q <= (o_q == '0) ? BCD_NINE : o_q - 4'd1;
   assign o_borrow = in_borrow && (o_q == '0);
endmodule

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: cascadable multi-digit BCD down counter with zero flag, terminal count and done pulse.
// Ports: in_clk clock; in_rst sync active-high reset; bus (slave) carries load/preset/enable in,
// count, zero, terminal count and done pulse out.
module bcd_down_counter
   import bcd_down_counter_pkg::*;
#(
   parameter int DIGITS = 2,
   parameter bit WRAP   = 1'b1
)(
   input  logic              in_clk,
   input  logic              in_rst,
   bcd_down_counter_if.slave bus
);
   localparam logic [4*DIGITS-1:0] ONE = (4*DIGITS)'(1);
   logic [4*DIGITS-1:0] q;
   logic [DIGITS:0]     borrow;
   logic                zero;
   logic                hold;
   assign borrow[0] = bus.in_en;
   assign zero      = (q == '0);
   // Halting at zero: freeze every digit instead of letting the borrow wrap them to nine.
   assign hold      = !WRAP && zero;
   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_dn u_digit (
         .in_clk    (in_clk),
         .in_rst    (in_rst),
         .in_load   (bus.in_load),
         .in_d      (bus.in_d[i*BCD_W +: BCD_W]),
         .in_borrow (borrow[i]),
         .in_hold   (hold),
         .o_q       (q[i*BCD_W +: BCD_W]),
         .o_borrow  (borrow[i+1])
      );
   end
   assign bus.o_q    = q;
   assign bus.o_zero = zero;
   // Borrow out of the top digit is exactly in_en with every digit at zero.
   assign bus.o_tc   = borrow[DIGITS];
   always_ff @(posedge in_clk)
      bus.o_done <= in_rst ? 1'b0 : (bus.in_en && !bus.in_load && q == ONE);
endmodule
